// File: rtl/riscv_mem_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and the load/store unit.
// Data side has priority; a saturating counter forces a fetch grant after STARVE_LIM losses.
module riscv_mem_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [ADDR_W-1:0]    if_addr,
  output logic                 if_ready,
  output logic                 if_valid,
  output logic [WIDTH-1:0]     if_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WIDTH/8-1:0]   d_be,
  input  logic [ADDR_W-1:0]    d_addr,
  input  logic [WIDTH-1:0]     d_wdata,
  output logic                 d_ready,
  output logic                 d_valid,
  output logic [WIDTH-1:0]     d_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [WIDTH/8-1:0]   mem_be,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [WIDTH-1:0]     mem_wdata,
  input  logic [WIDTH-1:0]     mem_rdata
);

  localparam int unsigned BeW = WIDTH / 8;
  localparam logic [3:0] StarveLim = 4'(STARVE_LIM);

  typedef enum logic [1:0] {RspNone, RspIf, RspD} rsp_e;

  rsp_e       rsp_sel_q, rsp_sel_d;
  logic [3:0] starve_q, starve_d;
  logic       d_pri, grant_if, grant_d;

  always_comb begin
    d_pri    = d_req && (starve_q < StarveLim);
    grant_if = !rst && if_req && !d_pri;
    grant_d  = !rst && d_req && !grant_if;

    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = d_addr;
    mem_wdata = d_wdata;
    if (grant_if) begin
      mem_en   = 1'b1;
      mem_be   = {BeW{1'b1}};
      mem_addr = if_addr;
    end else if (grant_d) begin
      mem_en = 1'b1;
      mem_we = d_we;
      mem_be = d_be;
    end

    if (!if_req || grant_if) begin
      starve_d = '0;
    end else if (grant_d && (starve_q < StarveLim)) begin
      starve_d = starve_q + 4'd1;
    end else begin
      starve_d = starve_q;
    end

    if (grant_if) begin
      rsp_sel_d = RspIf;
    end else if (grant_d && !d_we) begin
      rsp_sel_d = RspD;
    end else begin
      rsp_sel_d = RspNone;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_sel_q <= RspNone;
      starve_q  <= '0;
    end else begin
      rsp_sel_q <= rsp_sel_d;
      starve_q  <= starve_d;
    end
  end

  // Valids are masked while rst is high so a read granted just before reset never completes.
  assign if_ready = grant_if;
  assign d_ready  = grant_d;
  assign if_valid = !rst && (rsp_sel_q == RspIf);
  assign d_valid  = !rst && (rsp_sel_q == RspD);
  assign if_rdata = mem_rdata;
  assign d_rdata  = mem_rdata;

endmodule
